// File: rtl/mult_hp_pkg.sv
// Shared binary16 format constants and operand class type for the
// half-precision multiplier.
//
// Contents:
//   EXP_W, MAN_W  - exponent / fraction field widths
//   BIAS, EXP_MAX - exponent bias and largest finite biased exponent
//   QNAN, POS_INF - canonical quiet NaN and +infinity encodings
//   op_class_t    - operand class {ZERO, NORMAL, INF, NAN}
package mult_hp_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 30;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } op_class_t;

endpackage

// File: rtl/mult_hp_classify.sv
// Combinational decoder for one binary16 operand.
//
// Ports:
//   op   in  16  binary16 operand {sign, exp, frac}
//   cls  out     operand class (ZERO covers subnormals, which are flushed)
//   sig  out 11  significand with hidden bit, zero unless NORMAL
//   bexp out 5   biased exponent field as received
module mult_hp_classify
    import mult_hp_pkg::*;
(
    input  logic [15:0]      op,
    output op_class_t        cls,
    output logic [MAN_W:0]   sig,
    output logic [EXP_W-1:0] bexp
);

    logic [EXP_W-1:0] exp_fld;
    logic [MAN_W-1:0] frac_fld;

    assign exp_fld  = op[14:10];
    assign frac_fld = op[9:0];
    assign bexp     = exp_fld;

    always_comb begin
        cls = NORMAL;
        sig = {1'b1, frac_fld};
        if (exp_fld == '0) begin
            // Subnormals are treated as exact zero.
            cls = ZERO;
            sig = '0;
        end else if (exp_fld == '1) begin
            cls = (frac_fld == '0) ? INF : NAN;
            sig = '0;
        end
    end

endmodule

// File: rtl/mult_half_precision.sv
// Registered IEEE 754 binary16 multiplier, one cycle latency, one result
// per cycle. Subnormal inputs are flushed to zero and subnormal results
// are reported as underflow (signed zero with exception set).
//
// Ports:
//   i_Clk       in   1  rising-edge clock
//   i_Reset_n   in   1  synchronous active-low reset (clears outputs)
//   i_Factor1   in  16  operand A
//   i_Factor2   in  16  operand B
//   o_Product   out 16  registered product
//   o_Exception out  1  registered flag: NaN, inf, overflow or underflow
//
// Build option:
//   MULT_HP_ROUND_EN defined   -> round-to-nearest-even
//   MULT_HP_ROUND_EN undefined -> truncation toward zero
module mult_half_precision
    import mult_hp_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic [15:0] i_Factor1,
    input  logic [15:0] i_Factor2,
    output logic [15:0] o_Product,
    output logic        o_Exception
);

    // Returns {carry, mantissa} after rounding the 10-bit mantissa.
    function automatic logic [MAN_W:0] round_man(
        input logic [MAN_W-1:0] mant,
        input logic             guard,
        input logic             sticky
    );
`ifdef MULT_HP_ROUND_EN
        logic inc;
        // Ties (guard set, nothing below it) go to the even mantissa.
        inc       = guard & (sticky | mant[0]);
        round_man = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
`else
        logic discard_unused;
        // Truncation: the discarded bits have no effect on the result.
        discard_unused = guard | sticky;
        round_man      = {1'b0, mant};
`endif
    endfunction

    // Clamps a finite normal result; returns {exception, product}.
    function automatic logic [16:0] saturate(
        input logic              sign,
        input logic signed [7:0] e,
        input logic [MAN_W-1:0]  m
    );
        if (e > $signed(8'(EXP_MAX)))
            saturate = {1'b1, sign, POS_INF[14:0]};
        else if (e < 8'sd1)
            saturate = {1'b1, sign, 15'h0000};
        else
            saturate = {1'b0, sign, e[EXP_W-1:0], m};
    endfunction

    op_class_t         cls_a_p0, cls_b_p0;
    logic [MAN_W:0]    sig_a_p0, sig_b_p0;
    logic [EXP_W-1:0]  exp_a_p0, exp_b_p0;

    logic              sign_p0;
    logic [21:0]       prod_p0;
    logic signed [7:0] exp_sum_p0;
    logic signed [7:0] exp_norm_p0;
    logic signed [7:0] exp_fin_p0;
    logic [MAN_W-1:0]  mant_p0;
    logic              guard_p0;
    logic              sticky_p0;
    logic [MAN_W:0]    rnd_p0;
    logic [16:0]       normal_res_p0;
    logic [15:0]       product_p0;
    logic              exc_p0;

    logic [15:0]       product_p1;
    logic              exc_p1;

    mult_hp_classify u_class_a (
        .op   (i_Factor1),
        .cls  (cls_a_p0),
        .sig  (sig_a_p0),
        .bexp (exp_a_p0)
    );

    mult_hp_classify u_class_b (
        .op   (i_Factor2),
        .cls  (cls_b_p0),
        .sig  (sig_b_p0),
        .bexp (exp_b_p0)
    );

    // Stage p0: multiply, normalise, round and select the special cases.
    always_comb begin
        sign_p0    = i_Factor1[15] ^ i_Factor2[15];
        prod_p0    = {11'd0, sig_a_p0} * {11'd0, sig_b_p0};
        exp_sum_p0 = $signed({3'b000, exp_a_p0}) + $signed({3'b000, exp_b_p0})
                     - $signed(8'(BIAS));

        // Product of two [1,2) significands lies in [1,4).
        if (prod_p0[21]) begin
            mant_p0     = prod_p0[20:11];
            guard_p0    = prod_p0[10];
            sticky_p0   = |prod_p0[9:0];
            exp_norm_p0 = exp_sum_p0 + 8'sd1;
        end else begin
            mant_p0     = prod_p0[19:10];
            guard_p0    = prod_p0[9];
            sticky_p0   = |prod_p0[8:0];
            exp_norm_p0 = exp_sum_p0;
        end

        rnd_p0        = round_man(mant_p0, guard_p0, sticky_p0);
        // A carry out of rounding means the mantissa wrapped to zero (1.0 x 2).
        exp_fin_p0    = exp_norm_p0 + $signed({7'd0, rnd_p0[MAN_W]});
        normal_res_p0 = saturate(sign_p0, exp_fin_p0, rnd_p0[MAN_W-1:0]);

        product_p0 = normal_res_p0[15:0];
        exc_p0     = normal_res_p0[16];
        if (cls_a_p0 == NAN || cls_b_p0 == NAN) begin
            product_p0 = QNAN;
            exc_p0     = 1'b1;
        end else if ((cls_a_p0 == INF && cls_b_p0 == ZERO) ||
                     (cls_a_p0 == ZERO && cls_b_p0 == INF)) begin
            product_p0 = QNAN;
            exc_p0     = 1'b1;
        end else if (cls_a_p0 == INF || cls_b_p0 == INF) begin
            product_p0 = {sign_p0, POS_INF[14:0]};
            exc_p0     = 1'b1;
        end else if (cls_a_p0 == ZERO || cls_b_p0 == ZERO) begin
            product_p0 = {sign_p0, 15'h0000};
            exc_p0     = 1'b0;
        end
    end

    // Stage p1: output registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            product_p1 <= 16'h0000;
            exc_p1     <= 1'b0;
        end else begin
            product_p1 <= product_p0;
            exc_p1     <= exc_p0;
        end
    end

    assign o_Product   = product_p1;
    assign o_Exception = exc_p1;

endmodule

// File: tb/tb_mult_half_precision.sv
// Self-checking bench for mult_half_precision: fixed vector table, reset
// sequences, and back-to-back random operands checked against a
// real-arithmetic reference model.
module tb_mult_half_precision;

    logic        clk;
    logic        rst_n;
    logic [15:0] fa;
    logic [15:0] fb;
    logic [15:0] prod;
    logic        exc;

    int total;
    int bad;

    mult_half_precision dut (
        .i_Clk       (clk),
        .i_Reset_n   (rst_n),
        .i_Factor1   (fa),
        .i_Factor2   (fb),
        .o_Product   (prod),
        .o_Exception (exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        e;
    } vec_t;

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Exact real value of a normal x normal product magnitude.
    function automatic real exact_mag(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = 1024 + int'(a[9:0]); mb = 1024 + int'(b[9:0]);
        return real'(ma) * real'(mb) / 1048576.0 * pow2(ea + eb - 30);
    endfunction

    // Reference model: returns {exception, product}.
    function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   ea, eb, fra, frb, e, frac;
        bit   za, zb, ia, ib, na, nb;
        real  m, scaled, rem;
        s   = a[15] ^ b[15];
        ea  = int'(a[14:10]); eb = int'(b[14:10]);
        fra = int'(a[9:0]);   frb = int'(b[9:0]);
        za = (ea == 0);  zb = (eb == 0);
        ia = (ea == 31 && fra == 0); ib = (eb == 31 && frb == 0);
        na = (ea == 31 && fra != 0); nb = (eb == 31 && frb != 0);
        if (na || nb) return {1'b1, 16'h7E00};
        if ((ia && zb) || (ib && za)) return {1'b1, 16'h7E00};
        if (ia || ib) return {1'b1, s, 15'h7C00};
        if (za || zb) return {1'b0, s, 15'h0000};
        // Significand product in [1,4), scaled by 2^(ea+eb-30).
        m = real'((1024 + fra) * (1024 + frb)) / 1048576.0;
        e = ea + eb - 30;
        while (m >= 2.0) begin
            m = m / 2.0;
            e = e + 1;
        end
        scaled = (m - 1.0) * 1024.0;
        frac   = int'($floor(scaled));
        rem    = scaled - real'(frac);
`ifdef MULT_HP_ROUND_EN
        if (rem > 0.5 || (rem == 0.5 && (frac % 2) == 1)) frac = frac + 1;
`endif
        if (frac == 1024) begin
            frac = 0;
            e = e + 1;
        end
        e = e + 15;
        if (e > 30) return {1'b1, s, 15'h7C00};
        if (e < 1)  return {1'b1, s, 15'h0000};
        return {1'b0, s, 5'(e), 10'(frac)};
    endfunction

    task automatic check(input string nm, input logic [15:0] ap, input logic ae,
                         input logic [15:0] ep, input logic ee);
        total++;
        if (ap !== ep || ae !== ee) begin
            bad++;
            $display("FAIL %s: got prod=%h exc=%b, want prod=%h exc=%b",
                     nm, ap, ae, ep, ee);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector, advance one edge, compare to the model.
    task automatic apply_rand(input string nm, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        real act, ex, rel;
        fa = a; fb = b;
        r  = ref_mul(a, b);
        tick();
        check(nm, prod, exc, r[15:0], r[16]);
        // Finite nonzero normal results must be within one ulp of exact.
        if (r[16] == 1'b0 && a[14:10] != 5'd0 && b[14:10] != 5'd0) begin
            act = (1.0 + real'(prod[9:0]) / 1024.0) * pow2(int'(prod[14:10]) - 15);
            ex  = exact_mag(a, b);
            rel = (act > ex) ? (act - ex) / ex : (ex - act) / ex;
            total++;
            if (!(rel < 1.0 / 1024.0) || prod[14:10] == 5'd0) begin
                bad++;
                $display("FAIL %s_relerr: a=%h b=%h got=%h rel=%f want <%f",
                         nm, a, b, prod, rel, 1.0 / 1024.0);
            end
        end
    endtask

    vec_t tbl[12];

    initial begin
        logic [15:0] ra, rb;
        total = 0;
        bad   = 0;

        tbl[0]  = '{"one_x_two",   16'h3C00, 16'h4000, 16'h4000, 1'b0};
        tbl[1]  = '{"onehalf_sq",  16'h3E00, 16'h3E00, 16'h4080, 1'b0};
        tbl[2]  = '{"neg_two",     16'hC000, 16'h3C00, 16'hC000, 1'b0};
        tbl[3]  = '{"zero_x_big",  16'h0000, 16'h7800, 16'h0000, 1'b0};
        tbl[4]  = '{"negzero",     16'h8000, 16'h3C00, 16'h8000, 1'b0};
        tbl[5]  = '{"overflow",    16'h7800, 16'h4000, 16'h7C00, 1'b1};
        tbl[6]  = '{"underflow",   16'h0400, 16'h3800, 16'h0000, 1'b1};
        tbl[7]  = '{"nan_in",      16'h7E00, 16'h3C00, 16'h7E00, 1'b1};
        tbl[8]  = '{"inf_x_zero",  16'h7C00, 16'h0000, 16'h7E00, 1'b1};
        tbl[9]  = '{"neginf",      16'hFC00, 16'h4000, 16'hFC00, 1'b1};
`ifdef MULT_HP_ROUND_EN
        tbl[10] = '{"round",       16'h3E01, 16'h3E01, 16'h4082, 1'b0};
`else
        tbl[10] = '{"round",       16'h3E01, 16'h3E01, 16'h4081, 1'b0};
`endif
        tbl[11] = '{"subnorm_neg", 16'h0001, 16'hBC00, 16'h8000, 1'b0};

        // Reset held for two edges with live operands.
        rst_n = 1'b0;
        fa    = 16'h4000;
        fb    = 16'h4000;
        tick();
        check("reset_edge1", prod, exc, 16'h0000, 1'b0);
        tick();
        check("reset_edge2", prod, exc, 16'h0000, 1'b0);
        rst_n = 1'b1;
        tick();
        check("first_after_reset", prod, exc, 16'h4400, 1'b0);

        for (int i = 0; i < 12; i++) begin
            fa = tbl[i].a;
            fb = tbl[i].b;
            tick();
            check(tbl[i].name, prod, exc, tbl[i].p, tbl[i].e);
        end

        // Reset asserted mid-stream clears outputs, then operation resumes.
        fa    = 16'hFC00;
        fb    = 16'h4000;
        rst_n = 1'b0;
        tick();
        check("midstream_reset", prod, exc, 16'h0000, 1'b0);
        rst_n = 1'b1;
        fa    = 16'h3C00;
        fb    = 16'hC400;
        tick();
        check("resume", prod, exc, 16'hC400, 1'b0);

        // Back-to-back random normals, including overflow/underflow range.
        for (int i = 0; i < 300; i++) begin
            ra = {1'(($urandom)), 5'($urandom_range(1, 30)), 10'($urandom)};
            rb = {1'(($urandom)), 5'($urandom_range(1, 30)), 10'($urandom)};
            apply_rand("rand_normal", ra, rb);
        end

        // Back-to-back results staying comfortably in range.
        for (int i = 0; i < 200; i++) begin
            ra = {1'(($urandom)), 5'($urandom_range(8, 22)), 10'($urandom)};
            rb = {1'(($urandom)), 5'($urandom_range(8, 22)), 10'($urandom)};
            apply_rand("rand_mid", ra, rb);
        end

        // Any bit pattern, including specials and subnormals.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) ra = {ra[15], 5'h1F, ra[9:0]};
            if (i % 8 == 1) rb = {rb[15], 5'h00, rb[9:0]};
            apply_rand("rand_any", ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
